// File: rtl/poly_tone_pkg.sv
// Shared constants for the polyphonic tone bank: note half-period table for a
// 50 MHz clock, octave folding for keys beyond the first eight, and a popcount.
package poly_tone_pkg;

   localparam int unsigned CLK_HZ    = 50_000_000;
   localparam int unsigned NUM_NOTES = 8;

   function automatic int unsigned base_half(input int unsigned note);
      int unsigned h;
      case (note)
         0:       h = 95556;   // C4
         1:       h = 85131;   // D4
         2:       h = 75843;   // E4
         3:       h = 71586;   // F4
         4:       h = 63776;   // G4
         5:       h = 56818;   // A4
         6:       h = 50619;   // B4
         default: h = 47778;   // C5
      endcase
      return h;
   endfunction

   // Keys past the first eight reuse the table one octave higher per group of eight.
   function automatic int unsigned half_period(input int unsigned key);
      return base_half(key % NUM_NOTES) >> (key / NUM_NOTES);
   endfunction

   function automatic int unsigned count_ones(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one key input.
module key_debounce
   import poly_tone_pkg::*;
#(
   parameter int DB_CYCLES = 65536
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic deb
);

   localparam int DB_W = $clog2(DB_CYCLES);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] db_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // Any cycle where the synchronised level agrees with the accepted state restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb    <= 1'b0;
         db_cnt <= '0;
      end else if (sync2 == deb) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
         deb    <= ~deb;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/poly_tone_bank.sv
// Polyphonic key-to-tone bank: debounced keys compete for MAX_VOICES slots.
// Optional OCTAVE_SHIFT_EN adds octave_up, latched per key at its grant edge.
module poly_tone_bank
   import poly_tone_pkg::*;
#(
   parameter int NUM_KEYS   = 8,
   parameter int MAX_VOICES = 4,
   parameter int DB_CYCLES  = 65536,
   parameter int CNT_W      = 17
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_KEYS-1:0]               key_raw,
`ifdef OCTAVE_SHIFT_EN
   input  logic                              octave_up,
`endif
   output logic [NUM_KEYS-1:0]               tone_out,
   output logic [NUM_KEYS-1:0]               active_mask,
   output logic [$clog2(MAX_VOICES+1)-1:0]   voice_count,
   output logic                              overflow
);

   localparam int VC_W = $clog2(MAX_VOICES + 1);

   logic [NUM_KEYS-1:0] deb;
   logic [NUM_KEYS-1:0] grant_mask;
   logic [NUM_KEYS-1:0] rel_mask;
   logic [NUM_KEYS-1:0] mask_next;
   int                  n_cand;
   int                  free_slots;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .key_raw (key_raw[i]),
         .deb     (deb[i])
      );
   end

   // Free slots come from the registered count, so a slot released this cycle
   // is only offered to a waiting key on the following cycle.
   always_comb begin
      grant_mask = '0;
      rel_mask   = '0;
      n_cand     = 0;
      free_slots = MAX_VOICES - int'(voice_count);
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (deb[i] && !active_mask[i]) begin
            if (n_cand < free_slots) begin
               grant_mask[i] = 1'b1;
            end
            n_cand = n_cand + 1;
         end
         if (!deb[i] && active_mask[i]) begin
            rel_mask[i] = 1'b1;
         end
      end
      mask_next = (active_mask & ~rel_mask) | grant_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_mask <= '0;
         voice_count <= '0;
         overflow    <= 1'b0;
      end else begin
         active_mask <= mask_next;
         voice_count <= VC_W'(count_ones(32'(mask_next)));
         overflow    <= (n_cand > free_slots);
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_voice
      localparam int unsigned HALF_I = half_period(i);

      logic [CNT_W-1:0] tone_cnt;
      logic [CNT_W-1:0] tone_lim;
      logic             tone_q;

`ifdef OCTAVE_SHIFT_EN
      logic oct_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            oct_q <= 1'b0;
         end else if (grant_mask[i]) begin
            oct_q <= octave_up;
         end
      end

      assign tone_lim = oct_q ? CNT_W'((HALF_I >> 1) - 1) : CNT_W'(HALF_I - 1);
`else
      assign tone_lim = CNT_W'(HALF_I - 1);
`endif

      // Each grant restarts the waveform low so the first rise lands a full half-period later.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
         end else if (grant_mask[i]) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
         end else if (!active_mask[i] || rel_mask[i]) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
         end else if (tone_cnt == tone_lim) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
         end else begin
            tone_cnt <= tone_cnt + 1'b1;
         end
      end

      assign tone_out[i] = tone_q;
   end

endmodule

// File: tb/tb_poly_tone_bank.sv
// Self-checking bench for poly_tone_bank with a short debounce window; honours OCTAVE_SHIFT_EN.
module tb_poly_tone_bank;

   localparam int NK    = 8;
   localparam int MAXV  = 4;
   localparam int DB    = 4;
   localparam int CNTW  = 17;
   localparam int VCW   = $clog2(MAXV + 1);

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NK-1:0]   key_raw = '0;
   logic            octave_up = 1'b0;
   logic [NK-1:0]   tone_out;
   logic [NK-1:0]   active_mask;
   logic [VCW-1:0]  voice_count;
   logic            overflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   poly_tone_bank #(
      .NUM_KEYS   (NK),
      .MAX_VOICES (MAXV),
      .DB_CYCLES  (DB),
      .CNT_W      (CNTW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_raw),
`ifdef OCTAVE_SHIFT_EN
      .octave_up   (octave_up),
`endif
      .tone_out    (tone_out),
      .active_mask (active_mask),
      .voice_count (voice_count),
      .overflow    (overflow)
   );

   // Reference model: keys become "pressed" after DB consecutive disagreeing
   // synchronised samples; tone level is derived from cycles elapsed since grant.
   int  half_tab [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
   bit  m_s1  [NK];
   bit  m_s2  [NK];
   bit  m_deb [NK];
   int  m_run [NK];
   bit  m_act [NK];
   bit  m_oct [NK];
   int  m_age [NK];
   bit  m_g   [NK];
   bit  m_r   [NK];
   int  m_vc = 0;
   bit  m_ovf = 1'b0;
   int  m_free;
   int  m_ncand;

   function automatic int mhalf(input int i, input bit oct);
      return (half_tab[i % 8] >> (i / 8)) >> oct;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NK; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            m_act[i] = 0; m_oct[i] = 0; m_age[i] = 0;
         end
         m_vc  = 0;
         m_ovf = 0;
      end else begin
         m_free  = MAXV - m_vc;
         m_ncand = 0;
         for (int i = 0; i < NK; i++) begin
            m_g[i] = 0;
            m_r[i] = 0;
            if (m_deb[i] && !m_act[i]) begin
               m_ncand++;
               if (m_ncand <= m_free) m_g[i] = 1;
            end
            if (!m_deb[i] && m_act[i]) m_r[i] = 1;
         end
         m_ovf = (m_ncand > m_free);
         for (int i = 0; i < NK; i++) begin
            if (m_s2[i] != m_deb[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin
                  m_deb[i] = !m_deb[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = key_raw[i];
            if (m_g[i]) begin
               m_act[i] = 1;
               m_age[i] = 0;
               m_oct[i] = octave_up;
            end else if (m_r[i]) begin
               m_act[i] = 0;
               m_age[i] = 0;
            end else if (m_act[i]) begin
               m_age[i]++;
            end
         end
         m_vc = 0;
         for (int i = 0; i < NK; i++) m_vc += int'(m_act[i]);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   task automatic compareModel();
      logic [NK-1:0] e_mask;
      logic [NK-1:0] e_tone;
      for (int i = 0; i < NK; i++) begin
         e_mask[i] = m_act[i];
         e_tone[i] = m_act[i] ? (((m_age[i] / mhalf(i, m_oct[i])) % 2) == 1) : 1'b0;
      end
      checks++;
      if ({tone_out, active_mask, voice_count, overflow} !== {e_tone, e_mask, VCW'(m_vc), m_ovf}) begin
         failures++;
         $display("[TB] FAIL model at %0t: got tone=%h mask=%h vc=%0d ovf=%0b, expected tone=%h mask=%h vc=%0d ovf=%0b",
                  $time, tone_out, active_mask, voice_count, overflow, e_tone, e_mask, m_vc, m_ovf);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) compareModel();
   endtask

   task automatic applyStimulus(input logic [NK-1:0] raw, input int edges);
      key_raw = raw;
      repeat (edges) tick();
   endtask

   typedef struct {
      logic [NK-1:0]  raw;
      int             edges;
      logic [NK-1:0]  mask;
      logic [VCW-1:0] vc;
      logic           ovf;
   } vec_t;

   vec_t vecs [12];
   int   n;

   initial begin
      vecs[0]  = '{8'hFF,  6, 8'h00, 3'd0, 1'b0};
      vecs[1]  = '{8'hFF,  1, 8'h0F, 3'd4, 1'b1};
      vecs[2]  = '{8'h2D,  6, 8'h0F, 3'd4, 1'b1};
      vecs[3]  = '{8'h2D,  1, 8'h0D, 3'd3, 1'b1};
      vecs[4]  = '{8'h2D,  1, 8'h2D, 3'd4, 1'b0};
      vecs[5]  = '{8'h0D,  7, 8'h0D, 3'd3, 1'b0};
      vecs[6]  = '{8'h5D,  6, 8'h0D, 3'd3, 1'b0};
      vecs[7]  = '{8'h5D,  1, 8'h1D, 3'd4, 1'b1};
      vecs[8]  = '{8'h5D,  1, 8'h1D, 3'd4, 1'b1};
      vecs[9]  = '{8'h00,  7, 8'h00, 3'd0, 1'b0};
      vecs[10] = '{8'h04,  3, 8'h00, 3'd0, 1'b0};
      vecs[11] = '{8'h00, 10, 8'h00, 3'd0, 1'b0};

      // Reset with every key held: nothing may leak out while reset is high.
      key_raw = 8'hFF;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_tone",  32'(tone_out),    32'h0);
      checkOutput("reset_mask",  32'(active_mask), 32'h0);
      checkOutput("reset_vc",    32'(voice_count), 32'h0);
      checkOutput("reset_ovf",   32'(overflow),    32'h0);
      reset = 1'b0;

      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].raw, vecs[v].edges);
         checkOutput($sformatf("vec%0d_mask", v), 32'(active_mask), 32'(vecs[v].mask));
         checkOutput($sformatf("vec%0d_vc", v),   32'(voice_count), 32'(vecs[v].vc));
         checkOutput($sformatf("vec%0d_ovf", v),  32'(overflow),    32'(vecs[v].ovf));
         checkOutput($sformatf("vec%0d_tone", v), 32'(tone_out),    32'h0);
      end

      // Keys 0 and 7 together: grant latency, then key 7 (C5) first rise.
      key_raw = 8'h81;
      n = 0;
      do begin tick(); n++; end while (!active_mask[7] && n < 20);
      checkOutput("grant_latency", 32'(n), 32'd7);
      checkOutput("grant_mask", 32'(active_mask), 32'h81);
      n = 0;
      do begin tick(); n++; end while (!tone_out[7] && n < 60000);
      checkOutput("c5_first_rise", 32'(n), 32'd47778);
      checkOutput("c5_others_low", 32'(tone_out), 32'h80);

      // Reset mid-tone must silence outputs without waiting for a clock edge.
      #2 reset = 1'b1;
      #1;
      checkOutput("async_tone", 32'(tone_out),    32'h0);
      checkOutput("async_mask", 32'(active_mask), 32'h0);
      repeat (2) @(negedge clk);
      key_raw = '0;
      reset   = 1'b0;

      for (int r = 0; r < 400; r++) begin
         if ($urandom_range(0, 2) == 0) key_raw = NK'($urandom);
         else                           key_raw = key_raw ^ NK'(1 << $urandom_range(0, NK - 1));
         repeat ($urandom_range(1, 12)) tick();
      end
      applyStimulus('0, 12);
      checkOutput("idle_mask", 32'(active_mask), 32'h0);

`ifdef OCTAVE_SHIFT_EN
      // octave_up is captured at the grant edge only; dropping it afterwards changes nothing.
      octave_up = 1'b1;
      key_raw   = 8'h20;
      n = 0;
      do begin tick(); n++; end while (!active_mask[5] && n < 20);
      checkOutput("oct_grant_latency", 32'(n), 32'd7);
      octave_up = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!tone_out[5] && n < 40000);
      checkOutput("oct_first_rise", 32'(n), 32'd28409);
      applyStimulus('0, 12);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_tone_bank.md
Name: poly_tone_bank

Overview:
- Parametrised successor to the per-note switch/conditioner/LUT/tone chain. One block turns NUM_KEYS raw key inputs into square-wave tones.
- Per key it synchronises and debounces the input, then allocates the key to one of MAX_VOICES voice slots.
- Each granted key generates a square wave from a shared half-period table.
- It sits between the board switches and the speaker pins. It replaces the separate per-note modules and the enable LUT.

Parameters:
- NUM_KEYS, 8, number of key inputs / tone outputs (1..16)
- MAX_VOICES, 4, maximum simultaneously sounding keys (1..NUM_KEYS)
- DB_CYCLES, 65536, consecutive stable cycles required to accept a key change (>=2)
- CNT_W, 17, width of each tone half-period counter

Ports:
- clk, input, 1, system clock (50 MHz nominal)
- reset, input, 1, asynchronous, active-high reset
- key_raw, input, NUM_KEYS, unsynchronised switch/key levels, 1 = pressed
- tone_out, output, NUM_KEYS, per-key square wave, 1 bit per speaker
- active_mask, output, NUM_KEYS, 1 = key currently holds a voice
- voice_count, output, $clog2(MAX_VOICES+1), number of set bits in active_mask
- overflow, output, 1, 1 = some debounced-pressed key is denied a voice

Behaviour:
- Reset (async assert, sync deassert by the board) drives these to 0: all outputs, sync flops, debounce counters, debounced state, tone counters.
- Sync stage: 2-FF synchroniser per key, giving sync[i].
- Debounce per key:
  - The counter increments while sync[i] != deb[i] and clears whenever sync[i] == deb[i].
  - When the counter reaches DB_CYCLES-1 on a mismatching cycle, deb[i] flips and the counter clears.
  - Glitches shorter than DB_CYCLES never change deb[i].
- Allocation, evaluated every cycle from registered state:
  - free = MAX_VOICES - voice_count (registered value).
  - Candidates are keys with deb[i]=1 and active_mask[i]=0.
  - Up to free candidates are granted, lowest index first. active_mask[i] is set on the next edge.
  - A key with deb[i]=0 and active_mask[i]=1 is released: its mask clears on the next edge.
  - A release and a grant in the same cycle do not share the slot. The freed slot becomes usable one cycle later.
  - Denied candidates retry every cycle. No latching and no queue order beyond index priority.
- overflow = 1 (registered) when the number of candidates exceeds free.
- Tone generator per key:
  - On the grant edge: counter = 0, tone_out[i] = 0.
  - While active: counter++ each cycle. When counter == HALF[i]-1, counter returns to 0 and tone_out[i] toggles.
  - Period = 2*HALF[i] cycles; first rising edge at HALF[i] cycles after grant.
- On the release edge, tone_out[i] is forced to 0 and the counter clears.
- Key index i >= 8 uses HALF[i mod 8] >> (i/8), i.e. higher octaves.
- Latency from a clean key_raw edge to active_mask: 2 (sync) + DB_CYCLES + 1 (alloc) cycles.
- Reset mid-tone silences all outputs immediately. After deassert, keys still held re-debounce from scratch.

Optional Feature:
- Macro OCTAVE_SHIFT_EN.
- When defined:
  - Adds input port octave_up (1 bit).
  - octave_up is sampled at each key's grant edge and held per key while active.
  - If set, the key uses HALF[i] >> 1, one octave higher.
  - Changing octave_up while a key is held has no effect until re-grant.
- When undefined: the port is absent and HALF[i] is always used.

Decomposition:
- Package poly_tone_pkg holds the 8-entry half-period table for a 50 MHz clock:
  - C4 95556, D4 85131, E4 75843, F4 71586
  - G4 63776, A4 56818, B4 50619, C5 47778
- Package poly_tone_pkg also holds CLK_HZ = 50_000_000 and a count-ones function.
- One sub-module, key_debounce (synchroniser plus debounce for one key), is instantiated NUM_KEYS times.
- Allocation and tone counters live in the top.

Test Plan:
- Bench uses DB_CYCLES=4.
- Reset with key_raw=8'hFF held → all outputs 0 during reset. After deassert, active_mask=8'h0F at cycle 2+4+1, voice_count=4, overflow=1.
- Single key: key_raw=8'h01 → tone_out[0] rises 95556 cycles after grant and has period 191112. tone_out[7:1] stay 0.
- Glitch: key_raw[2] pulses high for 3 cycles → active_mask stays 0 and tone_out[2] never toggles.
- Voice steal-free handoff: with keys 0-3 active and key 5 pressed, release key 1 → mask clears, then key 5 is granted exactly 1 cycle later. overflow falls to 0.
- Simultaneous: with 3 voices active, press keys 4 and 6 in the same cycle → only key 4 is granted and overflow=1.
- Async reset asserted mid-tone → tone_out and active_mask go to 0 without a clock edge.
- (OCTAVE_SHIFT_EN) octave_up=1 at grant of key 5 → half-period 28409. Toggling octave_up later has no effect until re-press.
